// File: rtl/add_scheduler.sv
// Round-robin scheduler sharing one external adder among NUM_REQ requesters.
// Optional grant counter enabled by defining ADD_SCHEDULER_STATS_EN.
module add_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_on_off,
    input  logic [WIDTH-1:0]         add_c,
    input  logic                     add_carry_out,
    output logic [15:0]              grant_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    state_e               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_d;
    logic [IDW-1:0]       win_d;
    logic [NUM_REQ-1:0]   gnt_d;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [WIDTH-1:0]     a_sel_d;
    logic [WIDTH-1:0]     b_sel_d;
    logic [WIDTH-1:0]     add_a_q;
    logic [WIDTH-1:0]     add_b_q;
    logic                 add_en_q;
    logic                 rsp_valid_q;
    logic [IDW-1:0]       rsp_id_q;
    logic [WIDTH-1:0]     rsp_sum_q;
    logic                 rsp_carry_q;

    // Round-robin pick: first requester at or after ptr, wrapping.
    always_comb begin
        logic found;
        found = 1'b0;
        win_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win_d = IDW'(idx);
            end
        end
        ptr_d   = (win_d == IDW'(NUM_REQ - 1)) ? '0 : win_d + IDW'(1);
        gnt_d   = NUM_REQ'(1) << win_d;
        a_sel_d = a_in[int'(win_d)*WIDTH +: WIDTH];
        b_sel_d = b_in[int'(win_d)*WIDTH +: WIDTH];
    end

    // Transaction FSM; every visible output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            gnt_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q    <= gnt_d;
                        ptr_q    <= ptr_d;
                        add_a_q  <= a_sel_d;
                        add_b_q  <= b_sel_d;
                        add_en_q <= 1'b1;
                        rsp_id_q <= win_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum_q   <= add_c;
                    rsp_carry_q <= add_carry_out;
                    rsp_valid_q <= 1'b1;
                    add_en_q    <= 1'b0;
                    add_a_q     <= '0;
                    add_b_q     <= '0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ADD_SCHEDULER_STATS_EN
    logic [15:0] cnt_q;

    // Count every grant issued; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (state_q == IDLE && |req) cnt_q <= cnt_q + 16'd1;
    end

    assign grant_count = cnt_q;
`else
    assign grant_count = '0;
`endif

    assign gnt        = gnt_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign add_on_off = add_en_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_sum    = rsp_sum_q;
    assign rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_add_scheduler.sv
// Directed bench for add_scheduler with a behavioural adder.
// Grant-count expectation follows ADD_SCHEDULER_STATS_EN.
module tb_add_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_on_off;
    logic [7:0]  add_c;
    logic        add_carry_out;
    logic [15:0] grant_count;

    int checks = 0;
    int errors = 0;

    add_scheduler #(.WIDTH(8), .NUM_REQ(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .a_in          (a_in),
        .b_in          (b_in),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_sum       (rsp_sum),
        .rsp_carry     (rsp_carry),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_on_off    (add_on_off),
        .add_c         (add_c),
        .add_carry_out (add_carry_out),
        .grant_count   (grant_count)
    );

    always #5 clk = ~clk;

    assign {add_carry_out, add_c} = {1'b0, add_a} + {1'b0, add_b};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a,
                           input logic [7:0] b);
        a_in[i*8 +: 8] = a;
        b_in[i*8 +: 8] = b;
    endtask

    initial begin
        int exp_cnt;
        rst_n = 1'b0;
        req = '0;
        a_in = '0;
        b_in = '0;
        rsp_ready = 1'b1;
        nxt();
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_on", add_on_off, 0);
        chk("rst_a", add_a, 0);
        chk("rst_cnt", grant_count, 0);
        rst_n = 1'b1;
        nxt();

        // single request, no carry
        set_ops(0, 8'd5, 8'd10);
        req = 4'b0001;
        nxt();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_on", add_on_off, 1);
        chk("t1_a", add_a, 5);
        chk("t1_b", add_b, 10);
        chk("t1_valid_early", rsp_valid, 0);
        req = '0;
        nxt();
        chk("t1_gnt_off", gnt, 0);
        chk("t1_valid", rsp_valid, 1);
        chk("t1_id", rsp_id, 0);
        chk("t1_sum", rsp_sum, 15);
        chk("t1_carry", rsp_carry, 0);
        chk("t1_on_off", add_on_off, 0);
        chk("t1_a_zero", add_a, 0);
        nxt();
        chk("t1_done", rsp_valid, 0);

        // carry out, ptr moved past 0
        set_ops(2, 8'd250, 8'd21);
        req = 4'b0100;
        nxt();
        chk("t2_gnt", gnt, 4'b0100);
        req = '0;
        nxt();
        chk("t2_id", rsp_id, 2);
        chk("t2_sum", rsp_sum, 15);
        chk("t2_carry", rsp_carry, 1);
        nxt();

        // back-pressure in RESP with another request pending
        set_ops(1, 8'd100, 8'd100);
        rsp_ready = 1'b0;
        req = 4'b0010;
        nxt();
        chk("t3_gnt", gnt, 4'b0010);
        req = 4'b0001;
        nxt();
        chk("t3_valid", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            nxt();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_id", rsp_id, 1);
            chk("stall_sum", rsp_sum, 200);
            chk("stall_gnt", gnt, 0);
            chk("stall_on", add_on_off, 0);
        end
        rsp_ready = 1'b1;
        nxt();
        chk("t3_release", rsp_valid, 0);
        chk("t3_idle_gnt", gnt, 0);
        nxt();
        chk("t4_gnt", gnt, 4'b0001);
        req = '0;
        nxt();
        chk("t4_sum", rsp_sum, 15);
        chk("t4_id", rsp_id, 0);
        nxt();
`ifdef ADD_SCHEDULER_STATS_EN
        exp_cnt = 4;
`else
        exp_cnt = 0;
`endif
        chk("cnt_four", grant_count, exp_cnt);

        // reset while a response is pending
        rsp_ready = 1'b0;
        req = 4'b0100;
        nxt();
        chk("t5_gnt", gnt, 4'b0100);
        req = '0;
        nxt();
        chk("t5_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", rsp_valid, 0);
        chk("rst_sum_now", rsp_sum, 0);
        chk("rst_cnt_now", grant_count, 0);
        nxt();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        nxt();
        chk("abort_no_rsp", rsp_valid, 0);
        req = 4'b0110;
        nxt();
        chk("t6_gnt_low", gnt, 4'b0010);
        req = '0;
        nxt();
        chk("t6_id", rsp_id, 1);
        chk("t6_sum", rsp_sum, 200);
        nxt();

        // all requesting, rotation from ptr 0
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(10 * i + 1), 8'(i));
        req = 4'b1111;
        for (int k = 1; k <= 14; k++) begin
            nxt();
            if (k % 3 == 1) chk("rr_gnt", gnt, 4'b0001 << ((k / 3) % 4));
            else chk("rr_gnt_idle", gnt, 0);
            if (k % 3 == 2) begin
                chk("rr_id", rsp_id, (k / 3) % 4);
                chk("rr_sum", rsp_sum, 11 * ((k / 3) % 4) + 1);
            end
        end
        req = '0;
        nxt();
        nxt();
`ifdef ADD_SCHEDULER_STATS_EN
        exp_cnt = 5;
`else
        exp_cnt = 0;
`endif
        chk("cnt_rr", grant_count, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
